// File: rtl/readoutnet_pkg.sv
// Readout network packet format, shared by the sink decoder and the node-side NIs.
package readoutnet_pkg;

    localparam int PKT_W         = 32;
    localparam int TYPE_BIT      = 31;
    localparam int ID_MSB        = 30;
    localparam int ID_LSB        = 26;
    localparam int ID_W          = ID_MSB - ID_LSB + 1;
    localparam int SOF_BIT       = 25;
    localparam int OSC_PAYLOAD_W = 25;
    localparam int MEM_PAYLOAD_W = 24;
    localparam int OSC_IDX_W     = 5;
    localparam int OSC_ADDR_W    = ID_W + OSC_IDX_W;
    localparam int ERR_CNT_W     = 8;

    typedef enum logic {
        PKT_OSC = 1'b0,
        PKT_MEM = 1'b1
    } pkt_type_e;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/readout_osc_index_bank.sv
// Per-node oscillator index counters; each counter holds at NumOsc once a scan completes.
module readout_osc_index_bank
    import readoutnet_pkg::*;
#(
    parameter int NumNode = 8,
    parameter int NumOsc  = 25
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [ID_W-1:0]      node_i,
    input  logic                 sof_i,
    input  logic                 step_i,
    output logic [OSC_IDX_W-1:0] idx_o,
    output logic                 overrun_o
);

    localparam int CntW = $clog2(NumOsc + 1);

    logic [CntW-1:0] cnt_q [NumNode];
    logic [CntW-1:0] cnt_d [NumNode];
    logic [CntW-1:0] cnt_sel;

    always_comb begin
        cnt_sel = '0;
        for (int n = 0; n < NumNode; n++) begin
            if (node_i == ID_W'(n)) cnt_sel = cnt_q[n];
        end
    end

    assign overrun_o = ~sof_i & (cnt_sel == CntW'(NumOsc));
    assign idx_o     = sof_i ? '0 : OSC_IDX_W'(cnt_sel);

    // SOF restarts at index 0, so the next frame slot is 1
    always_comb begin
        for (int n = 0; n < NumNode; n++) begin
            cnt_d[n] = cnt_q[n];
            if (step_i && node_i == ID_W'(n)) begin
                if (sof_i)           cnt_d[n] = CntW'(1);
                else if (!overrun_o) cnt_d[n] = cnt_sel + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int n = 0; n < NumNode; n++) cnt_q[n] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/readout_sink_decoder.sv
// Readout network sink: splits memory packets to the host port and oscillator packets
// to result-file writes, counting dropped (bad ID / overrun) packets.
module readout_sink_decoder
    import readoutnet_pkg::*;
#(
    parameter int NumNode    = 8,
    parameter int NumOsc     = 25,
    parameter bit SimPresent = 1'b0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     Valid_i,
    input  logic [PKT_W-1:0]         Data_i,
    output logic                     Ready_o,
    output logic                     MemValid_o,
    output logic [ID_W-1:0]          MemId_o,
    output logic [MEM_PAYLOAD_W-1:0] MemData_o,
    input  logic                     MemReady_i,
    output logic                     OscWrEn_o,
    output logic [OSC_ADDR_W-1:0]    OscAddr_o,
    output logic [OSC_PAYLOAD_W-1:0] OscData_o,
    output logic                     ErrFlag_o,
    output logic [ERR_CNT_W-1:0]     ErrCnt_o,
    input  logic                     ClrErr_i
);

    pkt_type_e              pkt_type;
    logic [ID_W-1:0]        pkt_id;
    logic                   pkt_sof;
    logic                   id_ok;
    logic                   accept;
    logic                   osc_step;
    logic                   osc_wr;
    logic                   mem_load;
    logic                   drop;
    logic [OSC_IDX_W-1:0]   osc_idx;
    logic                   osc_overrun;

    logic                     mem_valid_q, mem_valid_d;
    logic [ID_W-1:0]          mem_id_q, mem_id_d;
    logic [MEM_PAYLOAD_W-1:0] mem_data_q, mem_data_d;
    logic                     osc_wr_q;
    logic [OSC_ADDR_W-1:0]    osc_addr_q, osc_addr_d;
    logic [OSC_PAYLOAD_W-1:0] osc_data_q, osc_data_d;
    logic                     err_flag_q, err_flag_d;
    logic [ERR_CNT_W-1:0]     err_cnt_q, err_cnt_d;

    assign pkt_type = pkt_type_e'(Data_i[TYPE_BIT]);
    assign pkt_id   = Data_i[ID_MSB:ID_LSB];
    assign pkt_sof  = Data_i[SOF_BIT];
    assign id_ok    = (32'(pkt_id) < NumNode);

    // Strict in-order: a pending memory packet stalls osc traffic too
    assign Ready_o  = ~mem_valid_q | MemReady_i;
    assign accept   = Valid_i & Ready_o;

    assign osc_step = accept & id_ok & (pkt_type == PKT_OSC);
    assign osc_wr   = osc_step & ~osc_overrun;
    assign mem_load = accept & id_ok & (pkt_type == PKT_MEM);
    assign drop     = accept & (~id_ok | (osc_step & osc_overrun));

    readout_osc_index_bank #(
        .NumNode (NumNode),
        .NumOsc  (NumOsc)
    ) u_index_bank (
        .clk       (clk),
        .rstn      (rstn),
        .node_i    (pkt_id),
        .sof_i     (pkt_sof),
        .step_i    (osc_step),
        .idx_o     (osc_idx),
        .overrun_o (osc_overrun)
    );

    always_comb begin
        mem_valid_d = mem_valid_q;
        mem_id_d    = mem_id_q;
        mem_data_d  = mem_data_q;
        if (mem_load) begin
            mem_valid_d = 1'b1;
            mem_id_d    = pkt_id;
            mem_data_d  = Data_i[MEM_PAYLOAD_W-1:0];
        end else if (MemReady_i) begin
            mem_valid_d = 1'b0;
        end

        osc_addr_d = osc_addr_q;
        osc_data_d = osc_data_q;
        if (osc_wr) begin
            osc_addr_d = {pkt_id, osc_idx};
            osc_data_d = Data_i[OSC_PAYLOAD_W-1:0];
        end

        err_flag_d = err_flag_q;
        err_cnt_d  = err_cnt_q;
        // A drop coinciding with a clear counts as the first error after the clear
        if (drop) begin
            err_flag_d = 1'b1;
            err_cnt_d  = ClrErr_i ? ERR_CNT_W'(1) : sat_inc(err_cnt_q);
        end else if (ClrErr_i) begin
            err_flag_d = 1'b0;
            err_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_valid_q <= 1'b0;
            mem_id_q    <= '0;
            mem_data_q  <= '0;
            osc_wr_q    <= 1'b0;
            osc_addr_q  <= '0;
            osc_data_q  <= '0;
            err_flag_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            mem_id_q    <= mem_id_d;
            mem_data_q  <= mem_data_d;
            osc_wr_q    <= osc_wr;
            osc_addr_q  <= osc_addr_d;
            osc_data_q  <= osc_data_d;
            err_flag_q  <= err_flag_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign MemValid_o = mem_valid_q;
    assign MemId_o    = mem_id_q;
    assign MemData_o  = mem_data_q;
    assign OscWrEn_o  = osc_wr_q;
    assign OscAddr_o  = osc_addr_q;
    assign OscData_o  = osc_data_q;
    assign ErrFlag_o  = err_flag_q;
    assign ErrCnt_o   = err_cnt_q;

    if (SimPresent) begin : g_sim_chk
        logic             stall_q;
        logic [PKT_W-1:0] data_prev_q;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                stall_q     <= 1'b0;
                data_prev_q <= '0;
            end else begin
                stall_q     <= Valid_i & ~Ready_o;
                data_prev_q <= Data_i;
            end
        end

        always_ff @(posedge clk) begin
            if (rstn) begin
                if (stall_q && Valid_i && Data_i != data_prev_q)
                    $error("readout_sink_decoder: Data_i changed while stalled");
                if (drop)
                    $error("readout_sink_decoder: packet dropped, Data_i=%h", Data_i);
            end
        end
    end

endmodule

// File: tb/tb_readout_sink_decoder.sv
// Directed self-checking bench for readout_sink_decoder (NumNode=8, NumOsc=25).
module tb_readout_sink_decoder;
    import readoutnet_pkg::*;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic                     Valid_i;
    logic [PKT_W-1:0]         Data_i;
    logic                     Ready_o;
    logic                     MemValid_o;
    logic [ID_W-1:0]          MemId_o;
    logic [MEM_PAYLOAD_W-1:0] MemData_o;
    logic                     MemReady_i;
    logic                     OscWrEn_o;
    logic [OSC_ADDR_W-1:0]    OscAddr_o;
    logic [OSC_PAYLOAD_W-1:0] OscData_o;
    logic                     ErrFlag_o;
    logic [ERR_CNT_W-1:0]     ErrCnt_o;
    logic                     ClrErr_i;

    int n_checks = 0;
    int n_pass   = 0;

    readout_sink_decoder #(
        .NumNode    (8),
        .NumOsc     (25),
        .SimPresent (1'b0)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .Valid_i    (Valid_i),
        .Data_i     (Data_i),
        .Ready_o    (Ready_o),
        .MemValid_o (MemValid_o),
        .MemId_o    (MemId_o),
        .MemData_o  (MemData_o),
        .MemReady_i (MemReady_i),
        .OscWrEn_o  (OscWrEn_o),
        .OscAddr_o  (OscAddr_o),
        .OscData_o  (OscData_o),
        .ErrFlag_o  (ErrFlag_o),
        .ErrCnt_o   (ErrCnt_o),
        .ClrErr_i   (ClrErr_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] osc_pkt(input int id, input bit sof, input int cnt);
        return {1'b0, 5'(id), sof, 25'(cnt)};
    endfunction

    function automatic logic [31:0] mem_pkt(input int id, input int dat);
        return {1'b1, 5'(id), 2'b00, 24'(dat)};
    endfunction

    function automatic logic [31:0] addr(input int id, input int idx);
        return {22'd0, 5'(id), 5'(idx)};
    endfunction

    initial begin
        rstn       = 1'b0;
        Valid_i    = 1'b0;
        Data_i     = '0;
        MemReady_i = 1'b0;
        ClrErr_i   = 1'b0;

        @(negedge clk);
        check("rst_ready",    32'(Ready_o),    1);
        check("rst_memvalid", 32'(MemValid_o), 0);
        check("rst_memid",    32'(MemId_o),    0);
        check("rst_memdata",  32'(MemData_o),  0);
        check("rst_wren",     32'(OscWrEn_o),  0);
        check("rst_addr",     32'(OscAddr_o),  0);
        check("rst_oscdata",  32'(OscData_o),  0);
        check("rst_errflag",  32'(ErrFlag_o),  0);
        check("rst_errcnt",   32'(ErrCnt_o),   0);
        rstn = 1'b1;

        // Full scan of node 3: SOF then 24 continuation packets, back to back
        for (int i = 0; i < 25; i++) begin
            Valid_i = 1'b1;
            Data_i  = osc_pkt(3, i == 0, 32'h1ABCD + i);
            @(negedge clk);
            check("scan_wren", 32'(OscWrEn_o), 1);
            check("scan_addr", 32'(OscAddr_o), addr(3, i));
            check("scan_data", 32'(OscData_o), 32'h1ABCD + i);
        end
        Valid_i = 1'b0;
        @(negedge clk);
        check("scan_idle_wren", 32'(OscWrEn_o), 0);

        // 26th packet overruns the completed scan
        Valid_i = 1'b1;
        Data_i  = osc_pkt(3, 1'b0, 32'h777);
        @(negedge clk);
        check("ovr_wren",    32'(OscWrEn_o), 0);
        check("ovr_errflag", 32'(ErrFlag_o), 1);
        check("ovr_errcnt",  32'(ErrCnt_o),  1);
        Data_i = osc_pkt(3, 1'b1, 32'h1234);
        @(negedge clk);
        check("resof_wren", 32'(OscWrEn_o), 1);
        check("resof_addr", 32'(OscAddr_o), addr(3, 0));
        check("resof_data", 32'(OscData_o), 32'h1234);

        // Memory packet held for 4 cycles stalls the following osc packet
        Data_i = mem_pkt(5, 32'hC0FFEE);
        @(negedge clk);
        check("mem_valid", 32'(MemValid_o), 1);
        check("mem_id",    32'(MemId_o),    5);
        check("mem_data",  32'(MemData_o),  32'hC0FFEE);
        check("mem_ready", 32'(Ready_o),    0);
        Data_i = osc_pkt(2, 1'b1, 32'h55);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_memvalid", 32'(MemValid_o), 1);
            check("stall_memdata",  32'(MemData_o),  32'hC0FFEE);
            check("stall_ready",    32'(Ready_o),    0);
            check("stall_wren",     32'(OscWrEn_o),  0);
        end
        MemReady_i = 1'b1;
        #1;
        check("release_ready", 32'(Ready_o), 1);
        @(negedge clk);
        check("release_memvalid", 32'(MemValid_o), 0);
        check("release_wren",     32'(OscWrEn_o),  1);
        check("release_addr",     32'(OscAddr_o),  addr(2, 0));
        check("release_data",     32'(OscData_o),  32'h55);

        // Out-of-range IDs are dropped and leave node counters alone
        Data_i = osc_pkt(9, 1'b1, 32'h99);
        @(negedge clk);
        check("badosc_wren",   32'(OscWrEn_o), 0);
        check("badosc_errcnt", 32'(ErrCnt_o),  2);
        Data_i = mem_pkt(9, 32'h123456);
        @(negedge clk);
        check("badmem_valid",  32'(MemValid_o), 0);
        check("badmem_errcnt", 32'(ErrCnt_o),   3);
        Data_i = osc_pkt(3, 1'b0, 32'h42);
        @(negedge clk);
        check("after_bad_wren", 32'(OscWrEn_o), 1);
        check("after_bad_addr", 32'(OscAddr_o), addr(3, 1));

        // Error counter saturation and clear
        Data_i = osc_pkt(20, 1'b0, 0);
        for (int i = 0; i < 300; i++) @(negedge clk);
        check("sat_errcnt",  32'(ErrCnt_o),  255);
        check("sat_errflag", 32'(ErrFlag_o), 1);
        Valid_i  = 1'b0;
        ClrErr_i = 1'b1;
        @(negedge clk);
        check("clr_errcnt",  32'(ErrCnt_o),  0);
        check("clr_errflag", 32'(ErrFlag_o), 0);
        Valid_i = 1'b1;
        @(negedge clk);
        check("clrdrop_errcnt",  32'(ErrCnt_o),  1);
        check("clrdrop_errflag", 32'(ErrFlag_o), 1);
        ClrErr_i = 1'b0;

        // Continuous mem stream, then reset mid-stream
        for (int i = 0; i < 6; i++) begin
            Data_i = mem_pkt(i, 32'h100 + i);
            @(negedge clk);
            check("stream_valid", 32'(MemValid_o), 1);
            check("stream_id",    32'(MemId_o),    i);
            check("stream_data",  32'(MemData_o),  32'h100 + i);
        end
        MemReady_i = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_memvalid", 32'(MemValid_o), 0);
        check("midrst_ready",    32'(Ready_o),    1);
        check("midrst_errcnt",   32'(ErrCnt_o),   0);
        check("midrst_errflag",  32'(ErrFlag_o),  0);
        check("midrst_wren",     32'(OscWrEn_o),  0);
        Valid_i = 1'b0;
        @(negedge clk);
        rstn    = 1'b1;
        Valid_i = 1'b1;
        Data_i  = osc_pkt(3, 1'b0, 32'hABC);
        @(negedge clk);
        check("postrst_n3_addr", 32'(OscAddr_o), addr(3, 0));
        check("postrst_n3_wren", 32'(OscWrEn_o), 1);
        Data_i = osc_pkt(2, 1'b0, 32'hDEF);
        @(negedge clk);
        check("postrst_n2_addr", 32'(OscAddr_o), addr(2, 0));
        check("postrst_n2_data", 32'(OscData_o), 32'hDEF);
        Valid_i = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
